// File: rtl/uart_rx_pkg.sv
// ----------------------------------------------------------------------------
// uart_rx_pkg
// Shared definitions for the UART receive frame controller: receive FSM state
// encoding, the legal oversampling ratios and default widths.
// No ports (package).
// ----------------------------------------------------------------------------
package uart_rx_pkg;

    localparam int DATA_WIDTH_DEF     = 8;
    localparam int PRESCALE_WIDTH_DEF = 6;

    // Legal Prescale values (ticks per bit).
    localparam int PRESCALE_8  = 8;
    localparam int PRESCALE_16 = 16;
    localparam int PRESCALE_32 = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// ----------------------------------------------------------------------------
// uart_rx_frame_ctrl_if
// Groups the frame controller's result bus and its handshake with the
// parity_check stage.
//   par_chk_en  : one-cycle strobe asking parity_check to evaluate
//   P_Data      : deserialized data byte
//   par_error   : registered parity result returned by parity_check
//   data_valid  : one-cycle pulse for a good frame
//   par_err     : parity error flag of the last frame
//   stp_err     : stop-bit error flag of the last frame
//   strt_glitch : one-cycle pulse for a false start bit
// master = frame controller, slave = consumer / parity_check side.
// ----------------------------------------------------------------------------
interface uart_rx_frame_ctrl_if
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
    logic                  par_chk_en;
    logic [DATA_WIDTH-1:0] P_Data;
    logic                  par_error;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;
    logic                  strt_glitch;

    modport master (
        output par_chk_en, P_Data, data_valid, par_err, stp_err, strt_glitch,
        input  par_error
    );

    modport slave (
        input  par_chk_en, P_Data, data_valid, par_err, stp_err, strt_glitch,
        output par_error
    );
endinterface

// File: rtl/uart_rx_edge_bit_cnt.sv
// ----------------------------------------------------------------------------
// uart_rx_edge_bit_cnt
// Oversampling edge counter and data bit counter of the UART receiver.
//   CLK, RST    : clock, asynchronous active-low reset
//   edge_en_i   : count edges (FSM outside IDLE); held at 0 otherwise
//   prescale_i  : latched ticks per bit
//   bit_clr_i   : clear the bit counter
//   bit_inc_i   : advance the bit counter
//   edge_cnt_o  : current edge within the bit, 0..prescale_i-1
//   bit_cnt_o   : index of the data bit being received
//   bit_end_o   : last edge of the current bit
// ----------------------------------------------------------------------------
module uart_rx_edge_bit_cnt #(
    parameter int PRESCALE_WIDTH = 6,
    parameter int BIT_CNT_WIDTH  = 3
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      edge_en_i,
    input  logic [PRESCALE_WIDTH-1:0] prescale_i,
    input  logic                      bit_clr_i,
    input  logic                      bit_inc_i,
    output logic [PRESCALE_WIDTH-1:0] edge_cnt_o,
    output logic [BIT_CNT_WIDTH-1:0]  bit_cnt_o,
    output logic                      bit_end_o
);

    logic [PRESCALE_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
    logic [BIT_CNT_WIDTH-1:0]  bit_cnt_q, bit_cnt_d;

    assign bit_end_o = edge_en_i && (edge_cnt_q == prescale_i - PRESCALE_WIDTH'(1));

    always_comb begin
        edge_cnt_d = edge_cnt_q + PRESCALE_WIDTH'(1);
        if (!edge_en_i || bit_end_o) begin
            edge_cnt_d = '0;
        end

        bit_cnt_d = bit_cnt_q;
        if (bit_clr_i) begin
            bit_cnt_d = '0;
        end else if (bit_inc_i) begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    assign edge_cnt_o = edge_cnt_q;
    assign bit_cnt_o  = bit_cnt_q;

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// ----------------------------------------------------------------------------
// uart_rx_frame_ctrl
// Receive frame controller: FSM, LSB-first deserializer and error flags.
//   CLK, RST    : oversampling clock, asynchronous active-low reset
//   RX_IN       : serial line, idle high
//   PAR_EN      : frame carries a parity bit (latched at start detection)
//   Prescale    : ticks per bit, 8/16/32 (latched at start detection)
//   sampled_bit : majority-voted bit from the data-sampling stage
//   dat_samp_en : enables the data-sampling stage (every state but IDLE)
//   rx_if       : result bus and parity_check handshake (master side)
// ----------------------------------------------------------------------------
module uart_rx_frame_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int PRESCALE_WIDTH = PRESCALE_WIDTH_DEF
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic                      PAR_EN,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic                      sampled_bit,
    output logic                      dat_samp_en,
    uart_rx_frame_ctrl_if.master      rx_if
);

    localparam int BIT_CNT_WIDTH = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    rx_state_e                 state_q, state_d;
    logic                      par_en_q;
    logic [PRESCALE_WIDTH-1:0] prescale_q;
    logic [DATA_WIDTH-1:0]     p_data_q;
    logic                      data_valid_q, par_err_q, stp_err_q, strt_glitch_q;

    logic [PRESCALE_WIDTH-1:0] edge_cnt;
    logic [BIT_CNT_WIDTH-1:0]  bit_cnt;
    logic                      bit_end;
    logic                      edge_en, bit_clr, bit_inc, par_chk_en;
    logic                      start_det, last_data_bit;

    assign start_det     = (state_q == IDLE) && !RX_IN;
    assign last_data_bit = (bit_cnt == BIT_CNT_WIDTH'(DATA_WIDTH - 1));

    uart_rx_edge_bit_cnt #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH),
        .BIT_CNT_WIDTH  (BIT_CNT_WIDTH)
    ) u_cnt (
        .CLK        (CLK),
        .RST        (RST),
        .edge_en_i  (edge_en),
        .prescale_i (prescale_q),
        .bit_clr_i  (bit_clr),
        .bit_inc_i  (bit_inc),
        .edge_cnt_o (edge_cnt),
        .bit_cnt_o  (bit_cnt),
        .bit_end_o  (bit_end)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d is defaulted before the case so every path assigns it;
    // a missing default would infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!RX_IN)  state_d = START;
            START:   if (bit_end) state_d = sampled_bit ? IDLE : DATA;
            DATA:    if (bit_end && last_data_bit) state_d = par_en_q ? PARITY : STOP;
            PARITY:  if (bit_end) state_d = STOP;
            STOP:    if (bit_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobe parity_check one tick before bit end so its registered result
    // is ready exactly when PARITY makes its decision.
    always_comb begin
        edge_en    = (state_q != IDLE);
        bit_clr    = (state_q == START) && bit_end;
        bit_inc    = (state_q == DATA) && bit_end;
        par_chk_en = (state_q == PARITY) &&
                     (edge_cnt == prescale_q - PRESCALE_WIDTH'(2));
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_en_q      <= 1'b0;
            prescale_q    <= '0;
            p_data_q      <= '0;
            data_valid_q  <= 1'b0;
            par_err_q     <= 1'b0;
            stp_err_q     <= 1'b0;
            strt_glitch_q <= 1'b0;
        end else begin
            data_valid_q  <= 1'b0;
            strt_glitch_q <= 1'b0;

            // Frame configuration is frozen for the whole frame.
            if (start_det) begin
                par_en_q   <= PAR_EN;
                prescale_q <= Prescale;
                par_err_q  <= 1'b0;
                stp_err_q  <= 1'b0;
            end

            if (bit_inc) begin
                p_data_q <= {sampled_bit, p_data_q[DATA_WIDTH-1:1]};
            end

            if ((state_q == START) && bit_end && sampled_bit) begin
                strt_glitch_q <= 1'b1;
            end

            if ((state_q == PARITY) && bit_end) begin
                par_err_q <= rx_if.par_error;
            end

            if ((state_q == STOP) && bit_end) begin
                stp_err_q    <= ~sampled_bit;
                data_valid_q <= sampled_bit & ~par_err_q;
            end
        end
    end

    assign dat_samp_en       = edge_en;
    assign rx_if.par_chk_en  = par_chk_en;
    assign rx_if.P_Data      = p_data_q;
    assign rx_if.data_valid  = data_valid_q;
    assign rx_if.par_err     = par_err_q;
    assign rx_if.stp_err     = stp_err_q;
    assign rx_if.strt_glitch = strt_glitch_q;

endmodule
